seven_seg_scanner: RTL and testbench



---
 rtl/seven_seg_scanner_pkg.sv | 24 ++
 rtl/seven_seg_scanner_seg_decoder.sv | 26 ++
 rtl/seven_seg_scanner.sv | 98 +++++++++
 tb/tb_seven_seg_scanner.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/seven_seg_scanner_pkg.sv
// Shared constants for the clock display path: digit indices and segment patterns.
package clock_disp_pkg;

  localparam int NUM_DIGITS = 6;

  localparam logic [2:0] IDX_SEC1  = 3'd0;
  localparam logic [2:0] IDX_SEC2  = 3'd1;
  localparam logic [2:0] IDX_MIN1  = 3'd2;
  localparam logic [2:0] IDX_MIN2  = 3'd3;
  localparam logic [2:0] IDX_HOUR1 = 3'd4;
  localparam logic [2:0] IDX_HOUR2 = 3'd5;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic {PH_VISIBLE, PH_HIDDEN} blink_phase_t;

  // Active-low one-hot digit enable for a given index.
  function automatic logic [NUM_DIGITS-1:0] an_of(input logic [2:0] idx);
    return ~(NUM_DIGITS'(1) << idx);
  endfunction

endpackage

// File: rtl/seven_seg_scanner_seg_decoder.sv
// Combinational BCD to active-low 7-segment decode; non-BCD codes show a dash.
module seg_decoder
  import clock_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Six-digit multiplexed 7-segment scanner with set-mode blink of the selected digit.
// Optional LEAD_ZERO_BLANK_EN suppresses a zero in the hours-tens position.
module seven_seg_scanner
  import clock_disp_pkg::*;
#(
  parameter int SCAN_DIV  = 100000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sec1,
  input  logic [3:0] sec2,
  input  logic [3:0] min1,
  input  logic [3:0] min2,
  input  logic [3:0] hour1,
  input  logic [3:0] hour2,
  input  logic       set,
  input  logic [2:0] select,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] an
);

  localparam int SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [SW-1:0] scnt;
  logic [BW-1:0] bcnt;
  logic [2:0]    idx;
  blink_phase_t  phase;

  logic [3:0] digit;
  logic [6:0] dec_seg;
  logic       blank;
  logic       lz;

  always_comb begin
    digit = sec1;
    case (idx)
      IDX_SEC1:  digit = sec1;
      IDX_SEC2:  digit = sec2;
      IDX_MIN1:  digit = min1;
      IDX_MIN2:  digit = min2;
      IDX_HOUR1: digit = hour1;
      IDX_HOUR2: digit = hour2;
      default:   digit = sec1;
    endcase
  end

  seg_decoder u_dec (
    .bcd (digit),
    .seg (dec_seg)
  );

  // select values 6/7 never equal idx, so they blank nothing.
  assign blank = set && (phase == PH_HIDDEN) && (idx == select);

`ifdef LEAD_ZERO_BLANK_EN
  assign lz = (idx == IDX_HOUR2) && (hour2 == 4'd0);
`else
  assign lz = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      scnt  <= '0;
      bcnt  <= '0;
      idx   <= IDX_SEC1;
      phase <= PH_VISIBLE;
      an    <= '1;
      seg   <= SEG_BLANK;
      dp    <= 1'b1;
    end else begin
      if (scnt == SW'(SCAN_DIV - 1)) begin
        scnt <= '0;
        idx  <= (idx == IDX_HOUR2) ? IDX_SEC1 : idx + 3'd1;
      end else begin
        scnt <= scnt + SW'(1);
      end

      // Leaving set mode parks the blinker so the next entry starts visible.
      if (!set) begin
        bcnt  <= '0;
        phase <= PH_VISIBLE;
      end else if (bcnt == BW'(BLINK_DIV - 1)) begin
        bcnt  <= '0;
        phase <= (phase == PH_VISIBLE) ? PH_HIDDEN : PH_VISIBLE;
      end else begin
        bcnt <= bcnt + BW'(1);
      end

      an  <= an_of(idx);
      seg <= (blank || lz) ? SEG_BLANK : dec_seg;
      dp  <= blank ? 1'b1 : !((idx == IDX_MIN1) || (idx == IDX_HOUR1));
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with SCAN_DIV=4, BLINK_DIV=16.
module tb_seven_seg_scanner;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sec1, sec2, min1, min2, hour1, hour2;
  logic       set;
  logic [2:0] select;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] an;

  int checks = 0;
  int errors = 0;

  logic [6:0] exp_seg [6];
  logic [6:0] exp_s;
  int         slot;
  int         blanked;

  seven_seg_scanner #(.SCAN_DIV(4), .BLINK_DIV(16)) dut (
    .clk(clk), .rst(rst),
    .sec1(sec1), .sec2(sec2), .min1(min1), .min2(min2),
    .hour1(hour1), .hour2(hour2),
    .set(set), .select(select),
    .seg(seg), .dp(dp), .an(an)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int slot_of(input logic [5:0] a);
    for (int i = 0; i < 6; i++)
      if (a == ~(6'd1 << i)) return i;
    return 7;
  endfunction

  // Steps at least once, then until the given slot is displayed.
  task automatic wait_slot(input int s);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (slot_of(an) != s && n < 40);
    if (slot_of(an) != s) chk("wait_slot timeout", {1'b0, an}, {1'b0, ~(6'd1 << s)});
  endtask

  initial begin
    exp_seg[0] = 7'b1111000; // 7
    exp_seg[1] = 7'b0010010; // 5
    exp_seg[2] = 7'b0110000; // 3
    exp_seg[3] = 7'b0011001; // 4
    exp_seg[4] = 7'b0010000; // 9
    exp_seg[5] = 7'b1111001; // 1

    rst = 1'b1; set = 1'b0; select = 3'd0;
    sec1 = 4'd7; sec2 = 4'd5; min1 = 4'd3; min2 = 4'd4; hour1 = 4'd9; hour2 = 4'd1;

    // Reset held three cycles.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset an", {1'b0, an}, 7'b0111111);
      chk("reset seg", seg, 7'b1111111);
      chk("reset dp", {6'd0, dp}, 7'd1);
    end
    rst = 1'b0;

    // One full rotation: each slot held 4 cycles, 1-cycle output latency.
    for (int k = 0; k < 24; k++) begin
      step();
      chk("scan an", {1'b0, an}, {1'b0, ~(6'd1 << (k / 4))});
      chk("scan seg", seg, exp_seg[k / 4]);
      chk("scan dp", {6'd0, dp}, ((k / 4) == 2 || (k / 4) == 4) ? 7'd0 : 7'd1);
    end
    step();
    chk("rotation wrap an", {1'b0, an}, 7'b0111110);

    // Non-BCD value shows a dash.
    sec1 = 4'd15;
    wait_slot(0);
    chk("dash seg", seg, 7'b0111111);
    sec1 = 4'd7;

    // Input change mid-slot lands exactly one cycle later.
    wait_slot(3);
    chk("min2 before", seg, 7'b0011001);
    min2 = 4'd0;
    step();
    chk("min2 latency an", {1'b0, an}, 7'b0110111);
    chk("min2 latency seg", seg, 7'b1000000);
    min2 = 4'd4;

    // Blink slot 2: visible 16 cycles after set rises, hidden 16, repeat.
    set = 1'b1; select = 3'd2; blanked = 0;
    for (int k = 0; k < 96; k++) begin
      step();
      slot = slot_of(an);
      chk("blink an onehot", {6'd0, slot < 6}, 7'd1);
      if (slot < 6) begin
        exp_s = (slot == 2 && ((k / 16) % 2) == 1) ? 7'b1111111 : exp_seg[slot];
        if (exp_s == 7'b1111111) blanked++;
        chk("blink seg", seg, exp_s);
        if (exp_s == 7'b1111111) chk("blink dp", {6'd0, dp}, 7'd1);
      end
    end
    chk("blink saw blank", {6'd0, blanked > 0}, 7'd1);

    // select=6 never matches any slot.
    set = 1'b0;
    step();
    set = 1'b1; select = 3'd6;
    for (int k = 0; k < 48; k++) begin
      step();
      slot = slot_of(an);
      if (slot < 6) chk("select6 seg", seg, exp_seg[slot]);
      else chk("select6 an", {1'b0, an}, 7'b0111110);
    end
    set = 1'b0;

    // Hours-tens zero.
    hour2 = 4'd0;
    wait_slot(5);
    chk("hour2 zero an", {1'b0, an}, 7'b0011111);
`ifdef LEAD_ZERO_BLANK_EN
    chk("hour2 zero seg", seg, 7'b1111111);
`else
    chk("hour2 zero seg", seg, 7'b1000000);
`endif
    hour2 = 4'd1;

    // Reset mid-scan blanks for one cycle, then restarts at slot 0.
    wait_slot(3);
    step();
    rst = 1'b1;
    step();
    chk("midreset an", {1'b0, an}, 7'b0111111);
    chk("midreset seg", seg, 7'b1111111);
    chk("midreset dp", {6'd0, dp}, 7'd1);
    rst = 1'b0;
    step();
    chk("after midreset an", {1'b0, an}, 7'b0111110);
    chk("after midreset seg", seg, exp_seg[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
